decode_pipe: RTL and testbench
==============================

# decode_pipe

RV32IM decode stage, directly downstream of the fetch stage: consumes the registered PC, PC+4 and instruction, reads the integer register file, generates the sign-extended immediate and control word, and registers everything into the decode/execute pipeline register. It detects load-use hazards from its own output register, asserts the fetch stall, and injects a bubble. It also hosts the register-file write port driven by writeback.

## Interface
- DWIDTH, 32, datapath width
- REG_COUNT, 32, architectural registers (x0 hardwired zero)
- Clk_Core  in  1  core clock
- Rst_Core_N  in  1  reset, asynchronous, active-low
- pc_fi / pc_plus_fi / instruct_fi  in  32 each  fetch-stage outputs
- flush_di  in  1  execute redirect; squash this stage
- wb_en_di  in  1  writeback write enable
- wb_rd_di  in  5  writeback destination
- wb_data_di  in  32  writeback data
- stall_do  out  1  load-use stall to fetch (feeds fetch stall input)
- pc_do / pc_plus_do  out  32 each  registered PC, PC+4
- rs1_data_do / rs2_data_do  out  32 each  register operands
- imm_do  out  32  sign-extended immediate
- rs1_do / rs2_do / rd_do  out  5 each  register indices (for forwarding)
- alu_op_do  out  alu_op_e  ALU/MDU operation
- alu_src_a_do  out  1  0=rs1, 1=PC
- alu_src_b_do  out  1  0=rs2, 1=imm
- reg_write_do / mem_read_do / mem_write_do / branch_do / jump_do  out  1 each  control
- funct3_do  out  3  branch condition / memory size
- wb_sel_do  out  2  0=ALU, 1=mem, 2=PC+4
- illegal_do  out  1  undecodable instruction

## Operation
- Opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (decoded as NOP). OP with funct7=0000001 selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Immediates: I, S, B, U, J formats, bit 31 sign-extended; B/J bit 0 = 0; U = {instr[31:12], 12'b0}.
- uses_rs1 false for LUI/AUIPC/JAL; uses_rs2 true only for BRANCH/STORE/OP.
- Load-use hazard: stall_do = mem_read_do && rd_do != 0 && ((uses_rs1 && rs1 == rd_do) || (uses_rs2 && rs2 == rd_do)) && !flush_di. Combinational from registered state and instruct_fi.
- Output register update priority: reset > flush_di (bubble) > stall_do (bubble, inputs held by fetch) > normal load.
- Bubble: all control outputs 0, alu_op_do = ALU_ADD, illegal_do 0; pc/data fields don't-care (load current inputs).
- Illegal opcode/funct: illegal_do = 1, reg_write/mem_read/mem_write/branch/jump all 0.
- Register file: synchronous write on posedge when wb_en_di && wb_rd_di != 0; asynchronous read; x0 reads 0.

## Timing
- Latency 1 cycle: instruct_fi sampled at edge N appears on outputs after edge N.
- Load-use costs exactly one bubble: stall_do high for one cycle; next cycle mem_read_do = 0, so stall drops.
- flush_di and stall_do in the same cycle: flush wins; stall_do forced 0.
- Reset: all outputs 0 (bubble). Register file cleared to 0. Reset mid-operation discards the in-flight instruction.
- wb write and read of the same register in one cycle: see Configuration.

## Configuration
- DECODE_WB_BYPASS_EN defined: when wb_en_di && wb_rd_di != 0 && wb_rd_di matches rs1/rs2, rs*_data_do loads wb_data_di (write-first).
- Not defined: reads return the pre-write value. Same-cycle WB→decode dependence must then be handled by execute forwarding.

## Structure
- Shared package rv32_pkg: alu_op_e enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), opcode localparams, INSTR_NOP = 32'h0000_0013, wb_sel encodings.
- Sub-module reg_file (REG_COUNT x DWIDTH, 2 read, 1 write, bypass under macro). Decode logic and pipeline register live in decode_pipe.

## Test plan
- 0x00500093 (addi x1,x0,5) → next cycle imm_do=5, rd_do=1, reg_write_do=1, alu_src_b_do=1, alu_op_do=ADD.
- 0x0000A103 (lw x2,0(x1)), then 0x002101B3 (add x3,x2,x2) → stall_do=1 one cycle, one bubble out, add emitted next cycle with rs1_do=rs2_do=2.
- Load-use stall coincident with flush_di=1 → stall_do=0, bubble out, following instruction loaded normally.
- wb_en_di=1, wb_rd_di=5, wb_data_di=0xDEADBEEF while decoding add x6,x5,x0 → rs1_data_do=0xDEADBEEF with macro; old value without. wb_rd_di=0 → x0 stays 0.
- 0x022081B3 (mul x3,x1,x2) → alu_op_do=MUL; 0x0220C1B3 → DIV.
- 0xFFFFFFFF → illegal_do=1, all write/memory controls 0; reset asserted mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32IM definitions: ALU/MDU operation encoding, major opcodes,
// writeback-select encodings, the decoded control word and small decode helpers.
package rv32_pkg;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDU  = 7'b0000001;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] wb_sel;
        logic       illegal;
    } ctrl_t;

    // Control word of a bubble: nothing is written, ALU adds.
    localparam ctrl_t CTRL_BUBBLE = '{ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      1'b0, 1'b0, WB_SEL_ALU, 1'b0};

    // Base-ISA operation selected by funct3 (OP and OP-IMM share the map).
    function automatic alu_op_e alu_base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // M-extension operation selected by funct3.
    function automatic alu_op_e alu_mdu_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

    // Sign-extended immediate; formats without their own layout fall back to I.
    function automatic logic [31:0] imm_gen(input logic [31:0] instr);
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC: return {instr[31:12], 12'b0};
            OPC_JAL:            return {{12{instr[31]}}, instr[19:12], instr[20],
                                        instr[30:21], 1'b0};
            OPC_BRANCH:         return {{20{instr[31]}}, instr[7], instr[30:25],
                                        instr[11:8], 1'b0};
            OPC_STORE:          return {{21{instr[31]}}, instr[30:25], instr[11:7]};
            default:            return {{21{instr[31]}}, instr[30:20]};
        endcase
    endfunction

endpackage

// File: rtl/decode_pipe_reg_file.sv
// Integer register file: two asynchronous read ports, one synchronous write
// port, x0 hardwired to zero. Optional write-first bypass on the read ports is
// enabled by defining DECODE_WB_BYPASS_EN; otherwise reads return the pre-write value.
module reg_file #(
    parameter int DWIDTH    = 32,
    parameter int REG_COUNT = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DWIDTH-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DWIDTH-1:0] rd_data_b
);

    logic [DWIDTH-1:0] regs [REG_COUNT];
    logic              wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    // Architectural state: cleared on reset, written by writeback.
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            // NOTE: the array is reset deliberately (software may rely on zeroed
            // registers); that rules out mapping it onto a reset-less RAM macro.
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports: x0 returns zero; optional write-first forwarding.
    always_comb begin
        // NOTE: outputs get a default before any condition so no latch is inferred.
        rd_data_a = '0;
        rd_data_b = '0;
        if (rd_addr_a != '0) rd_data_a = regs[rd_addr_a];
        if (rd_addr_b != '0) rd_data_b = regs[rd_addr_b];
`ifdef DECODE_WB_BYPASS_EN
        if (wr_live && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
        if (wr_live && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
`else
        // Same-cycle writeback dependences are resolved by execute forwarding.
`endif
    end

endmodule

// File: rtl/decode_pipe.sv
// RV32IM decode stage: decodes the fetched instruction, reads the register file,
// builds the immediate and control word, and registers them into the
// decode/execute pipeline register. Detects load-use hazards against its own
// output register, stalls fetch and inserts a bubble. Hosts the writeback port.
// Build option: DECODE_WB_BYPASS_EN enables write-first register-file bypass.
module decode_pipe
    import rv32_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int REG_COUNT = 32
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    input  logic [DWIDTH-1:0] pc_fi,
    input  logic [DWIDTH-1:0] pc_plus_fi,
    input  logic [31:0]       instruct_fi,
    input  logic              flush_di,
    input  logic              wb_en_di,
    input  logic [4:0]        wb_rd_di,
    input  logic [DWIDTH-1:0] wb_data_di,
    output logic              stall_do,
    output logic [DWIDTH-1:0] pc_do,
    output logic [DWIDTH-1:0] pc_plus_do,
    output logic [DWIDTH-1:0] rs1_data_do,
    output logic [DWIDTH-1:0] rs2_data_do,
    output logic [31:0]       imm_do,
    output logic [4:0]        rs1_do,
    output logic [4:0]        rs2_do,
    output logic [4:0]        rd_do,
    output alu_op_e           alu_op_do,
    output logic              alu_src_a_do,
    output logic              alu_src_b_do,
    output logic              reg_write_do,
    output logic              mem_read_do,
    output logic              mem_write_do,
    output logic              branch_do,
    output logic              jump_do,
    output logic [2:0]        funct3_do,
    output logic [1:0]        wb_sel_do,
    output logic              illegal_do
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [DWIDTH-1:0] rs1_data;
    logic [DWIDTH-1:0] rs2_data;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              bubble;
    logic              dec_illegal;
    ctrl_t             dec_ctrl;
    ctrl_t             ctrl_q;

    assign opcode = instruct_fi[6:0];
    assign rd     = instruct_fi[11:7];
    assign funct3 = instruct_fi[14:12];
    assign rs1    = instruct_fi[19:15];
    assign rs2    = instruct_fi[24:20];
    assign funct7 = instruct_fi[31:25];

    reg_file #(
        .DWIDTH    (DWIDTH),
        .REG_COUNT (REG_COUNT),
        .ADDR_W    (5)
    ) u_reg_file (
        .Clk_Core   (Clk_Core),
        .Rst_Core_N (Rst_Core_N),
        .wr_en      (wb_en_di),
        .wr_addr    (wb_rd_di),
        .wr_data    (wb_data_di),
        .rd_addr_a  (rs1),
        .rd_data_a  (rs1_data),
        .rd_addr_b  (rs2),
        .rd_data_b  (rs2_data)
    );

    // Operand usage for hazard detection.
    assign uses_rs1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    assign uses_rs2 = opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};

    // Load-use: the load now in execute writes a register this instruction reads.
    assign stall_do = ctrl_q.mem_read && (rd_do != 5'd0) &&
                      ((uses_rs1 && (rs1 == rd_do)) || (uses_rs2 && (rs2 == rd_do))) &&
                      !flush_di;

    // A flush or a stall both turn this cycle's load into a bubble.
    assign bubble = flush_di || stall_do;

    // Instruction decode into the control word; illegal encodings are neutralised.
    always_comb begin
        dec_ctrl    = CTRL_BUBBLE;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_ctrl.alu_op    = ALU_PASS_B;
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec_ctrl.alu_src_a = 1'b1;
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec_ctrl.alu_src_a = 1'b1;
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.wb_sel    = WB_SEL_PC4;
            end
            OPC_JALR: begin
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.wb_sel    = WB_SEL_PC4;
                dec_illegal        = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_ctrl.alu_op = ALU_SUB;
                dec_ctrl.branch = 1'b1;
                dec_illegal     = funct3 inside {3'b010, 3'b011};
            end
            OPC_LOAD: begin
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.mem_read  = 1'b1;
                dec_ctrl.wb_sel    = WB_SEL_MEM;
                dec_illegal        = funct3 inside {3'b011, 3'b110, 3'b111};
            end
            OPC_STORE: begin
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                dec_illegal        = funct3[2] || (funct3 == 3'b011);
            end
            OPC_OP_IMM: begin
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = alu_base_op(funct3);
                if (funct3 == 3'b001) begin
                    dec_illegal = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       dec_ctrl.alu_op = ALU_SRA;
                    else if (funct7 != F7_BASE) dec_illegal = 1'b1;
                end
            end
            OPC_OP: begin
                dec_ctrl.reg_write = 1'b1;
                case (funct7)
                    F7_BASE: dec_ctrl.alu_op = alu_base_op(funct3);
                    F7_MDU:  dec_ctrl.alu_op = alu_mdu_op(funct3);
                    F7_ALT: begin
                        if (funct3 == 3'b000)      dec_ctrl.alu_op = ALU_SUB;
                        else if (funct3 == 3'b101) dec_ctrl.alu_op = ALU_SRA;
                        else                       dec_illegal = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_MISC_MEM: begin
                // FENCE retires as a NOP in this in-order pipeline.
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_ctrl         = CTRL_BUBBLE;
            dec_ctrl.illegal = 1'b1;
        end
    end

    // Decode/execute pipeline register; bubbles clear only the control word.
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            ctrl_q      <= '0;
            pc_do       <= '0;
            pc_plus_do  <= '0;
            rs1_data_do <= '0;
            rs2_data_do <= '0;
            imm_do      <= '0;
            rs1_do      <= '0;
            rs2_do      <= '0;
            rd_do       <= '0;
            funct3_do   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            ctrl_q      <= bubble ? CTRL_BUBBLE : dec_ctrl;
            pc_do       <= pc_fi;
            pc_plus_do  <= pc_plus_fi;
            rs1_data_do <= rs1_data;
            rs2_data_do <= rs2_data;
            imm_do      <= imm_gen(instruct_fi);
            rs1_do      <= rs1;
            rs2_do      <= rs2;
            rd_do       <= rd;
            funct3_do   <= funct3;
        end
    end

    assign alu_op_do    = ctrl_q.alu_op;
    assign alu_src_a_do = ctrl_q.alu_src_a;
    assign alu_src_b_do = ctrl_q.alu_src_b;
    assign reg_write_do = ctrl_q.reg_write;
    assign mem_read_do  = ctrl_q.mem_read;
    assign mem_write_do = ctrl_q.mem_write;
    assign branch_do    = ctrl_q.branch;
    assign jump_do      = ctrl_q.jump;
    assign wb_sel_do    = ctrl_q.wb_sel;
    assign illegal_do   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed cases plus a randomized
// instruction stream checked against a behavioural decode and register model.
// Honours DECODE_WB_BYPASS_EN for the expected same-cycle writeback behaviour.
module tb_decode_pipe;
    import rv32_pkg::*;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        Clk_Core;
    logic        Rst_Core_N;
    logic [31:0] pc_fi, pc_plus_fi, instruct_fi;
    logic        flush_di, wb_en_di;
    logic [4:0]  wb_rd_di;
    logic [31:0] wb_data_di;
    logic        stall_do;
    logic [31:0] pc_do, pc_plus_do, rs1_data_do, rs2_data_do, imm_do;
    logic [4:0]  rs1_do, rs2_do, rd_do;
    alu_op_e     alu_op_do;
    logic        alu_src_a_do, alu_src_b_do, reg_write_do, mem_read_do;
    logic        mem_write_do, branch_do, jump_do, illegal_do;
    logic [2:0]  funct3_do;
    logic [1:0]  wb_sel_do;

    decode_pipe dut (
        .Clk_Core     (Clk_Core),
        .Rst_Core_N   (Rst_Core_N),
        .pc_fi        (pc_fi),
        .pc_plus_fi   (pc_plus_fi),
        .instruct_fi  (instruct_fi),
        .flush_di     (flush_di),
        .wb_en_di     (wb_en_di),
        .wb_rd_di     (wb_rd_di),
        .wb_data_di   (wb_data_di),
        .stall_do     (stall_do),
        .pc_do        (pc_do),
        .pc_plus_do   (pc_plus_do),
        .rs1_data_do  (rs1_data_do),
        .rs2_data_do  (rs2_data_do),
        .imm_do       (imm_do),
        .rs1_do       (rs1_do),
        .rs2_do       (rs2_do),
        .rd_do        (rd_do),
        .alu_op_do    (alu_op_do),
        .alu_src_a_do (alu_src_a_do),
        .alu_src_b_do (alu_src_b_do),
        .reg_write_do (reg_write_do),
        .mem_read_do  (mem_read_do),
        .mem_write_do (mem_write_do),
        .branch_do    (branch_do),
        .jump_do      (jump_do),
        .funct3_do    (funct3_do),
        .wb_sel_do    (wb_sel_do),
        .illegal_do   (illegal_do)
    );

    initial Clk_Core = 1'b0;
    always #5 Clk_Core = ~Clk_Core;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected decode of one instruction, derived from the ISA tables.
    typedef struct packed {
        logic [4:0]  op;
        logic        a, b, rw, mr, mw, br, jp;
        logic [1:0]  wb;
        logic        ill;
        logic        has_imm;
        logic [31:0] imm;
    } mdl_t;

    // Reference model state.
    logic [31:0] mregs [32];
    logic        e_mr;
    logic [4:0]  e_rd;
    logic        obs_stall;
    logic        last_exp_stall;

    function automatic mdl_t model_decode(input logic [31:0] ins);
        mdl_t        m;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] ii, is, ib, iu, ij;
        logic        ok;
        alu_op_e     base_tab [8];
        base_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        // Immediates from arithmetic shifts and bit masks.
        ii = 32'($signed(ins) >>> 20);
        is = (ii & ~32'h1F) | {27'b0, ins[11:7]};
        ib = (is & ~32'h801) | ({31'b0, ins[7]} << 11);
        iu = ins & 32'hFFFF_F000;
        ij = (ii & 32'hFFF0_07FE) | (ins & 32'h000F_F000) | ({31'b0, ins[20]} << 11);
        m = '0;
        m.op = 5'(ALU_ADD);
        ok = 1'b1;
        case (opc)
            OPC_LUI:   begin m.op = 5'(ALU_PASS_B); m.b = 1; m.rw = 1; m.has_imm = 1; m.imm = iu; end
            OPC_AUIPC: begin m.a = 1; m.b = 1; m.rw = 1; m.has_imm = 1; m.imm = iu; end
            OPC_JAL:   begin m.a = 1; m.b = 1; m.rw = 1; m.jp = 1; m.wb = 2; m.has_imm = 1; m.imm = ij; end
            OPC_JALR:  begin ok = (f3 == 0); m.b = 1; m.rw = 1; m.jp = 1; m.wb = 2; m.has_imm = 1; m.imm = ii; end
            OPC_BRANCH: begin ok = !(f3 == 2 || f3 == 3); m.op = 5'(ALU_SUB); m.br = 1; m.has_imm = 1; m.imm = ib; end
            OPC_LOAD:  begin ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                             m.b = 1; m.rw = 1; m.mr = 1; m.wb = 1; m.has_imm = 1; m.imm = ii; end
            OPC_STORE: begin ok = (f3 < 3); m.b = 1; m.mw = 1; m.has_imm = 1; m.imm = is; end
            OPC_OP_IMM: begin
                m.b = 1; m.rw = 1; m.has_imm = 1; m.imm = ii;
                m.op = 5'(base_tab[f3]);
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    if (f7 == 7'h20) m.op = 5'(ALU_SRA);
                    else ok = (f7 == 0);
                end
            end
            OPC_OP: begin
                m.rw = 1;
                if (f7 == 7'h00)      m.op = 5'(base_tab[f3]);
                else if (f7 == 7'h01) m.op = 5'(ALU_MUL) + 5'(f3);
                else if (f7 == 7'h20 && f3 == 0) m.op = 5'(ALU_SUB);
                else if (f7 == 7'h20 && f3 == 5) m.op = 5'(ALU_SRA);
                else ok = 1'b0;
            end
            OPC_MISC_MEM: ;
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            m = '0;
            m.op = 5'(ALU_ADD);
            m.ill = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r, input logic we,
                                               input logic [4:0] wrd, input logic [31:0] wdat);
        if (r == 0) return 32'h0;
        if (BYPASS && we && wrd == r) return wdat;
        return mregs[r];
    endfunction

    // One decode cycle: apply inputs, check the stall, clock, check the register.
    task automatic drive_cycle(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                               input logic we, input logic [4:0] wrd, input logic [31:0] wdat);
        mdl_t        d;
        logic        exp_stall, bub, u1, u2;
        logic [4:0]  r1, r2;
        logic [31:0] v1, v2;
        instruct_fi = ins;
        pc_fi       = pc;
        pc_plus_fi  = pc + 32'd4;
        flush_di    = fl;
        wb_en_di    = we;
        wb_rd_di    = wrd;
        wb_data_di  = wdat;
        #1;
        r1 = ins[19:15];
        r2 = ins[24:20];
        u1 = !(ins[6:0] == OPC_LUI || ins[6:0] == OPC_AUIPC || ins[6:0] == OPC_JAL);
        u2 = (ins[6:0] == OPC_BRANCH || ins[6:0] == OPC_STORE || ins[6:0] == OPC_OP);
        exp_stall = e_mr && (e_rd != 0) && ((u1 && r1 == e_rd) || (u2 && r2 == e_rd)) && !fl;
        check("stall", 32'(stall_do), 32'(exp_stall));
        obs_stall      = stall_do;
        last_exp_stall = exp_stall;
        v1  = model_read(r1, we, wrd, wdat);
        v2  = model_read(r2, we, wrd, wdat);
        d   = model_decode(ins);
        bub = fl || exp_stall;
        if (bub) begin
            d = '0;
            d.op = 5'(ALU_ADD);
        end
        @(posedge Clk_Core);
        #1;
        if (we && wrd != 0) mregs[wrd] = wdat;
        e_mr = d.mr;
        e_rd = ins[11:7];
        check("alu_op",    32'(alu_op_do),    32'(d.op));
        check("alu_src_a", 32'(alu_src_a_do), 32'(d.a));
        check("alu_src_b", 32'(alu_src_b_do), 32'(d.b));
        check("reg_write", 32'(reg_write_do), 32'(d.rw));
        check("mem_read",  32'(mem_read_do),  32'(d.mr));
        check("mem_write", 32'(mem_write_do), 32'(d.mw));
        check("branch",    32'(branch_do),    32'(d.br));
        check("jump",      32'(jump_do),      32'(d.jp));
        check("wb_sel",    32'(wb_sel_do),    32'(d.wb));
        check("illegal",   32'(illegal_do),   32'(d.ill));
        if (!bub) begin
            check("pc",       pc_do,             pc);
            check("pc_plus",  pc_plus_do,        pc + 32'd4);
            check("rs1_data", rs1_data_do,       v1);
            check("rs2_data", rs2_data_do,       v2);
            check("rs1",      32'(rs1_do),       32'(r1));
            check("rs2",      32'(rs2_do),       32'(r2));
            check("rd",       32'(rd_do),        32'(ins[11:7]));
            check("funct3",   32'(funct3_do),    32'(ins[14:12]));
            if (d.has_imm) check("imm", imm_do, d.imm);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stall"},   32'(stall_do),     32'h0);
        check({tag, "_pc"},      pc_do,             32'h0);
        check({tag, "_pcp"},     pc_plus_do,        32'h0);
        check({tag, "_d1"},      rs1_data_do,       32'h0);
        check({tag, "_d2"},      rs2_data_do,       32'h0);
        check({tag, "_imm"},     imm_do,            32'h0);
        check({tag, "_idx"},     32'({rs1_do, rs2_do, rd_do, funct3_do}), 32'h0);
        check({tag, "_aluop"},   32'(alu_op_do),    32'(ALU_ADD));
        check({tag, "_ctrl"},    32'({alu_src_a_do, alu_src_b_do, reg_write_do, mem_read_do,
                                      mem_write_do, branch_do, jump_do, wb_sel_do, illegal_do}),
                                 32'h0);
    endtask

    // Asynchronous reset in the middle of a cycle, released on a falling edge.
    task automatic reset_mid(input string tag);
        #2;
        Rst_Core_N = 1'b0;
        #1;
        check_zero(tag);
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        e_mr = 1'b0;
        e_rd = 5'd0;
        last_exp_stall = 1'b0;
        @(negedge Clk_Core);
        @(negedge Clk_Core);
        Rst_Core_N = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opc_tab [10];
        logic [6:0]  f7;
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        int          k;
        opc_tab = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                    OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM};
        k = int'($urandom_range(0, 13));
        if (k >= 12) return $urandom;
        rd = 5'($urandom_range(0, 3));
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        f3 = 3'($urandom);
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        if (k >= 10) return {f7, r2, r1, f3, rd, OPC_LOAD};
        return {f7, r2, r1, f3, rd, opc_tab[k]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cur_ins, cur_pc;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        e_mr = 1'b0;
        e_rd = 5'd0;
        last_exp_stall = 1'b0;
        obs_stall = 1'b0;
        Rst_Core_N  = 1'b0;
        instruct_fi = INSTR_NOP;
        pc_fi = 32'h0;
        pc_plus_fi = 32'h4;
        flush_di = 1'b0;
        wb_en_di = 1'b0;
        wb_rd_di = 5'd0;
        wb_data_di = 32'h0;
        #13;
        check_zero("reset");
        @(negedge Clk_Core);
        Rst_Core_N = 1'b1;

        // addi x1,x0,5
        drive_cycle(32'h0050_0093, 32'h100, 0, 0, 0, 0);
        check("addi_imm",  imm_do,               32'd5);
        check("addi_rd",   32'(rd_do),           32'd1);
        check("addi_rw",   32'(reg_write_do),    32'd1);
        check("addi_srcb", 32'(alu_src_b_do),    32'd1);
        check("addi_op",   32'(alu_op_do),       32'(ALU_ADD));

        // lw x2,0(x1) then add x3,x2,x2: one stall cycle, one bubble
        drive_cycle(32'h0000_A103, 32'h104, 0, 0, 0, 0);
        drive_cycle(32'h0021_01B3, 32'h108, 0, 0, 0, 0);
        check("lu_stall",       32'(obs_stall),    32'd1);
        check("lu_bubble_rw",   32'(reg_write_do), 32'd0);
        check("lu_bubble_mr",   32'(mem_read_do),  32'd0);
        drive_cycle(32'h0021_01B3, 32'h108, 0, 0, 0, 0);
        check("lu_release",     32'(obs_stall),    32'd0);
        check("lu_add_rs1",     32'(rs1_do),       32'd2);
        check("lu_add_rs2",     32'(rs2_do),       32'd2);
        check("lu_add_rw",      32'(reg_write_do), 32'd1);

        // load-use hazard coincident with flush
        drive_cycle(32'h0000_A103, 32'h10C, 0, 0, 0, 0);
        drive_cycle(32'h0021_01B3, 32'h110, 1, 0, 0, 0);
        check("fl_stall",  32'(obs_stall),    32'd0);
        check("fl_rw",     32'(reg_write_do), 32'd0);
        drive_cycle(32'h0070_0213, 32'h200, 0, 0, 0, 0);
        check("fl_next_rw",  32'(reg_write_do), 32'd1);
        check("fl_next_imm", imm_do,            32'd7);
        check("fl_next_rd",  32'(rd_do),        32'd4);

        // writeback vs same-cycle read of x5
        drive_cycle(INSTR_NOP, 32'h204, 0, 1, 5'd5, 32'h0000_1234);
        drive_cycle(32'h0002_8333, 32'h208, 0, 1, 5'd5, 32'hDEAD_BEEF);
        check("wb_same_cycle", rs1_data_do, BYPASS ? 32'hDEAD_BEEF : 32'h0000_1234);
        drive_cycle(32'h0002_8333, 32'h20C, 0, 0, 0, 0);
        check("wb_after", rs1_data_do, 32'hDEAD_BEEF);
        drive_cycle(32'h0000_0333, 32'h210, 0, 1, 5'd0, 32'hFFFF_FFFF);
        check("x0_same_cycle", rs1_data_do, 32'h0);
        drive_cycle(32'h0000_0333, 32'h214, 0, 0, 0, 0);
        check("x0_after", rs1_data_do, 32'h0);

        // M extension
        drive_cycle(32'h0220_81B3, 32'h218, 0, 0, 0, 0);
        check("mul_op", 32'(alu_op_do), 32'(ALU_MUL));
        drive_cycle(32'h0220_C1B3, 32'h21C, 0, 0, 0, 0);
        check("div_op", 32'(alu_op_do), 32'(ALU_DIV));

        // illegal instruction
        drive_cycle(32'hFFFF_FFFF, 32'h220, 0, 0, 0, 0);
        check("ill_flag", 32'(illegal_do), 32'd1);
        check("ill_ctrl", 32'({reg_write_do, mem_read_do, mem_write_do, branch_do, jump_do}), 32'd0);

        // reset mid-stream, then confirm the register file was cleared
        drive_cycle(32'h0050_0093, 32'h224, 0, 0, 0, 0);
        reset_mid("rst_mid");
        drive_cycle(32'h0002_8333, 32'h300, 0, 0, 0, 0);
        check("rst_rf_cleared", rs1_data_do, 32'h0);

        // randomized stream; fetch holds its outputs while stalled
        cur_pc  = 32'h1000;
        cur_ins = INSTR_NOP;
        for (int i = 0; i < 1500; i++) begin
            if (!last_exp_stall) begin
                cur_ins = rand_instr();
                cur_pc  = cur_pc + 32'd4;
            end
            drive_cycle(cur_ins, cur_pc, ($urandom_range(0, 9) == 0),
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            if (i == 750) begin
                reset_mid("rst_rand");
                cur_ins = INSTR_NOP;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
